// File: rtl/router_pkt_tx.sv
// router_pkt_tx: source end of the router's header/payload/parity byte
// protocol. Accepts a request, buffers the payload, replays it to the
// router while honouring busy, then watches err for a few idle cycles.
module router_pkt_tx #(
    parameter int GAP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_addr,
    input  logic [5:0] req_len,
    input  logic       pld_valid,
    output logic       pld_ready,
    input  logic [7:0] pld_data,
    input  logic       abort,
    input  logic       busy,
    input  logic       err,
    output logic [7:0] tx_data,
    output logic       pkt_valid,
    output logic       tx_done,
    output logic       bad_req,
    output logic       tx_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        HEADER  = 3'd2,
        PAYLOAD = 3'd3,
        PARITY  = 3'd4,
        GAP     = 3'd5
    } state_t;

    // GAP lasts GAP_CYCLES cycles: the counter is loaded with one less and
    // the exit happens at the edge where it reads zero.
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [1:0]  addr_reg, addr_next;
    logic [5:0]  len_reg, len_next;
    logic [7:0]  par_reg, par_next;
    logic [5:0]  wcnt_reg, wcnt_next;
    logic [5:0]  rcnt_reg, rcnt_next;
    logic [3:0]  gap_reg, gap_next;
    logic [7:0]  tx_data_reg, tx_data_next;
    logic        pkt_valid_reg, pkt_valid_next;
    logic        tx_done_reg, tx_done_next;
    logic        bad_req_reg, bad_req_next;
    logic        tx_err_reg, tx_err_next;

    // Payload buffer; contents are never cleared, only overwritten.
    logic [7:0]  mem [0:63];
    logic        pld_fire;

    assign req_ready = (state_reg == IDLE);
    assign pld_ready = (state_reg == LOAD);
    assign pld_fire  = pld_ready && pld_valid;

    assign tx_data   = tx_data_reg;
    assign pkt_valid = pkt_valid_reg;
    assign tx_done   = tx_done_reg;
    assign bad_req   = bad_req_reg;
    assign tx_err    = tx_err_reg;

    // Buffer write port: one accepted payload byte per cycle during LOAD.
    always_ff @(posedge clock) begin
        if (pld_fire) begin
            mem[wcnt_reg] <= pld_data;
        end
    end

    // Next-state and next-output logic; bus outputs are computed here and
    // registered below so they only move on state/counter updates.
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        len_next       = len_reg;
        par_next       = par_reg;
        wcnt_next      = wcnt_reg;
        rcnt_next      = rcnt_reg;
        gap_next       = gap_reg;
        tx_data_next   = tx_data_reg;
        pkt_valid_next = pkt_valid_reg;
        tx_done_next   = 1'b0;
        bad_req_next   = 1'b0;
        tx_err_next    = tx_err_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    tx_err_next = 1'b0;
                    addr_next   = req_addr;
                    len_next    = req_len;
                    par_next    = {req_len, req_addr};
                    wcnt_next   = 6'd0;
                    rcnt_next   = 6'd0;
                    if (req_addr == 2'd3 || req_len == 6'd0) begin
                        bad_req_next = 1'b1;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (pld_valid) begin
                    par_next  = par_reg ^ pld_data;
                    wcnt_next = wcnt_reg + 6'd1;
                    if (wcnt_reg == len_reg - 6'd1) begin
                        state_next     = HEADER;
                        tx_data_next   = {len_reg, addr_reg};
                        pkt_valid_next = 1'b1;
                    end
                end
            end
            HEADER: begin
                if (!busy) begin
                    state_next   = PAYLOAD;
                    tx_data_next = mem[rcnt_reg];
                end
            end
            PAYLOAD: begin
                if (!busy) begin
                    if (rcnt_reg == len_reg - 6'd1) begin
                        state_next     = PARITY;
                        tx_data_next   = par_reg;
                        pkt_valid_next = 1'b0;
                    end else begin
                        rcnt_next    = rcnt_reg + 6'd1;
                        tx_data_next = mem[rcnt_reg + 6'd1];
                    end
                end
            end
            PARITY: begin
                if (!busy) begin
                    state_next   = GAP;
                    tx_data_next = 8'd0;
                    tx_done_next = 1'b1;
                    gap_next     = GAP_LOAD;
                end
            end
            GAP: begin
                if (err) begin
                    tx_err_next = 1'b1;
                end
                if (gap_reg == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_reg - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort overrides everything outside IDLE, including a byte consumed
        // at the same edge; the error verdict is left as it was.
        if (abort && state_reg != IDLE) begin
            state_next     = IDLE;
            tx_data_next   = 8'd0;
            pkt_valid_next = 1'b0;
            tx_done_next   = 1'b0;
            tx_err_next    = tx_err_reg;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            addr_reg      <= 2'd0;
            len_reg       <= 6'd0;
            par_reg       <= 8'd0;
            wcnt_reg      <= 6'd0;
            rcnt_reg      <= 6'd0;
            gap_reg       <= 4'd0;
            tx_data_reg   <= 8'd0;
            pkt_valid_reg <= 1'b0;
            tx_done_reg   <= 1'b0;
            bad_req_reg   <= 1'b0;
            tx_err_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            len_reg       <= len_next;
            par_reg       <= par_next;
            wcnt_reg      <= wcnt_next;
            rcnt_reg      <= rcnt_next;
            gap_reg       <= gap_next;
            tx_data_reg   <= tx_data_next;
            pkt_valid_reg <= pkt_valid_next;
            tx_done_reg   <= tx_done_next;
            bad_req_reg   <= bad_req_next;
            tx_err_reg    <= tx_err_next;
        end
    end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter for the router's input port: the source end of the header/payload/parity byte protocol consumed by the router's input FSM. It accepts a packet request (destination, length) plus a payload byte stream, buffers the payload, and drives `tx_data`/`pkt_valid` into the router. It stalls on `busy` and reports the router's parity-error verdict. It sits in the packet-source wrapper, directly in front of the router's `data_in`/`pkt_valid`/`busy`/`err` pins.

## Interface
- `GAP_CYCLES`, default 2: idle cycles after the parity byte, while `err` is watched. Legal range 1..15.
- `clock` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: packet request valid.
- `req_ready` out 1: request accepted when `req_valid && req_ready` at a rising edge.
- `req_addr` in 2: destination port; 0..2 legal, 3 illegal.
- `req_len` in 6: payload length in bytes; 1..63 legal, 0 illegal.
- `pld_valid` in 1: payload byte valid.
- `pld_ready` out 1: payload byte accepted when `pld_valid && pld_ready`.
- `pld_data` in 8: payload byte.
- `abort` in 1: synchronous abort.
- `busy` in 1: router busy; the current byte is not consumed while high.
- `err` in 1: router parity-error flag.
- `tx_data` out 8: byte to router `data_in`.
- `pkt_valid` out 1: high for header and payload bytes, low for the parity byte and when idle.
- `tx_done` out 1: one-cycle pulse when the parity byte is consumed.
- `bad_req` out 1: one-cycle pulse when an illegal request is dropped.
- `tx_err` out 1: sticky; set if `err` is seen during GAP; cleared on the next request acceptance.

## Operation
- States: IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
- IDLE:
  - `req_ready`=1.
  - On acceptance, latch addr/len, clear `tx_err`, and set `par` = header.
  - Header = {len[5:0], addr[1:0]}.
  - Illegal request (addr==3 or len==0): pulse `bad_req` the next cycle and stay in IDLE.
  - Legal request: go to LOAD.
- LOAD:
  - `pld_ready`=1.
  - Each accepted byte is written to a 64x8 buffer at index `wcnt`, and `par ^= byte`.
  - After the len-th byte, go to HEADER.
- HEADER: `tx_data`=header, `pkt_valid`=1.
- PAYLOAD:
  - `tx_data`=buf[`rcnt`], `pkt_valid`=1.
  - `rcnt` advances on each consumed byte.
  - After byte len-1 is consumed, go to PARITY.
- PARITY:
  - `tx_data`=`par`, `pkt_valid`=0.
  - When consumed, pulse `tx_done` and go to GAP.
- GAP:
  - `tx_data`=0, `pkt_valid`=0, down-count GAP_CYCLES.
  - `err`=1 in any GAP cycle sets `tx_err`.
  - Go to IDLE when the count expires.
- Consumption rule: a byte is consumed at a rising edge in HEADER/PAYLOAD/PARITY with `busy`=0. While `busy`=1, `tx_data`, `pkt_valid` and the state all hold.
- `tx_data`/`pkt_valid` are registered. They change only on state/counter updates.
- `abort`=1 at an edge in any state except IDLE:
  - Next state IDLE, `pkt_valid`=0, `tx_data`=0.
  - `tx_done` is not pulsed; `tx_err` is unchanged.
  - In IDLE, `abort` is ignored.
- `wcnt`/`rcnt` are 6-bit and reset to 0 on each acceptance. Buffer contents are never cleared.

## Timing
- Reset values (asynchronous, all outputs):
  - state IDLE, `req_ready`=1, `pld_ready`=0.
  - `tx_data`=0, `pkt_valid`=0, `tx_done`=0, `bad_req`=0, `tx_err`=0.
  - Counters = 0.
- `resetn` low mid-packet: outputs go to reset values immediately, without waiting for a clock edge.
- Latency with a legal request accepted at edge T0 and payload streaming continuously:
  - `pld_ready` is high from T0 through the edge accepting byte len (edge T0+len).
  - The header is on the bus in the cycle after the last payload acceptance.
- Bus occupancy with `busy`=0: exactly len+2 cycles (header, len payload bytes, parity). `pkt_valid` falls in the same cycle the parity byte appears.
- Each `busy`=1 cycle extends the current byte by exactly one cycle. `busy` during GAP has no effect.
- `req_ready` returns high GAP_CYCLES cycles after the `tx_done` pulse cycle.
- `pld_valid` gaps during LOAD only delay the header; they never corrupt the packet.
- Simultaneous events:
  - `abort` and a consumed byte at the same edge: `abort` wins.
  - `err` in the same cycle as the GAP exit is still captured.

## Test plan
- Basic packet:
  - Stimulus: addr=1, len=3, payload 0x11,0x22,0x33, `busy`=0.
  - Bus sequence: 0x0D/pv1, 0x11/pv1, 0x22/pv1, 0x33/pv1, then 0x0D/pv0.
  - `tx_done` pulses once; `req_ready` returns after 2 GAP cycles.
- Busy stall:
  - Stimulus: same packet, `busy`=1 for 2 cycles during header and 1 cycle during payload byte 0x22.
  - The header is held 3 cycles and 0x22 is held 2 cycles; the sequence and parity are unchanged.
- Maximum length:
  - Stimulus: addr=2, len=63, payload 0x00..0x3E.
  - Header=0xFE; 63 payload bytes in order; parity = 0xFE XOR (XOR of 0x00..0x3E).
  - No counter wrap error.
- Illegal requests:
  - Stimulus: addr=3, len=5; then addr=0, len=0.
  - Each gives one `bad_req` pulse, `pld_ready` stays 0, and the bus stays idle.
- Router error:
  - Stimulus: `err`=1 in the second GAP cycle.
  - `tx_err`=1 and it stays set until the next request is accepted.
- Abort and reset:
  - Stimulus: `abort` in PAYLOAD after 2 bytes.
  - Next cycle: `pkt_valid`=0, `tx_data`=0, no `tx_done`, `req_ready`=1.
  - Separately, `resetn` low mid-LOAD forces all reset values without a clock edge.
